// File: rtl/io_output_buffered.sv
// Buffered output channel: formats the AC word as a sign symbol, N digit
// symbols and an end symbol, queues them in a small symbol FIFO and drains
// the FIFO to the output device over a 4-phase rdy/ack handshake.
module io_output_buffered #(
    parameter int         OCT_DIGITS = 10,
    parameter int         DEC_DIGITS = 7,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [4:0] END_CODE   = 5'b00110
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start_output,
    input  logic                          stop_output,
    input  logic                          oct_mode,
    input  logic                          dec_mode,
    input  logic                          stop_after_output,
    input  logic                          sign_from_ac,
    input  logic [3:0]                    digit_from_au,
    input  logic                          ac_answer,
    output logic                          order_io_to_ac,
    output logic                          shift_3_bit_to_ac,
    output logic                          shift_4_bit_to_ac,
    output logic                          output_active,
    output logic                          start_pulse_to_pu,
    output logic                          output_rdy_to_dev,
    input  logic                          output_ack_from_dev,
    output logic [4:0]                    output_data_to_dev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = $clog2((OCT_DIGITS > DEC_DIGITS ? OCT_DIGITS : DEC_DIGITS) + 1);
    localparam logic [KW-1:0] OCT_N = KW'(OCT_DIGITS);
    localparam logic [KW-1:0] DEC_N = KW'(DEC_DIGITS);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        F_IDLE, F_SIGN, F_DIGIT, F_REQ, F_WAIT, F_END, F_DRAIN
    } fmt_state_t;

    typedef enum logic [1:0] {
        D_IDLE, D_RDY, D_ACK, D_FLUSH
    } dev_state_t;

    fmt_state_t fmt_state_reg, fmt_state_next;
    dev_state_t dev_state_reg, dev_state_next;

    // symbol FIFO
    logic [4:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic          fifo_push, fifo_pop, fifo_empty, fifo_full, can_push;
    logic [4:0]    push_data, fifo_head;

    // formatter datapath
    logic          oct_reg, dec_reg;
    logic [KW-1:0] k_reg, k_inc, n_digits;
    logic [4:0]    digit_sym;
    logic          start_accept, drain_done, start_pulse_reg;

    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LEVEL);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign can_push   = !fifo_full || fifo_pop;
    assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];

    assign n_digits   = oct_reg ? OCT_N : DEC_N;
    assign k_inc      = k_reg + 1'b1;
    assign digit_sym  = oct_reg ? {2'b10, digit_from_au[3:1]} : {1'b1, digit_from_au};

    // Only an idle channel with exactly one format selected takes a start; abort wins.
    assign start_accept = (fmt_state_reg == F_IDLE) && start_output && !stop_output
                          && (oct_mode ^ dec_mode);
    // Word is complete once every symbol has left the FIFO and the device handshake closed.
    assign drain_done   = (fmt_state_reg == F_DRAIN) && fifo_empty && (dev_state_reg == D_IDLE);

    assign start_pulse_to_pu = start_pulse_reg;

    // FIFO storage write (no reset needed, contents only read when valid)
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // FIFO pointers; abort flushes the queue in one cycle
    always_ff @(posedge clk) begin
        if (!resetn || stop_output) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Formatter state register
    always_ff @(posedge clk) begin
        if (!resetn || stop_output) begin
            fmt_state_reg <= F_IDLE;
        end else begin
            fmt_state_reg <= fmt_state_next;
        end
    end

    // Formatter next-state logic
    always_comb begin
        fmt_state_next = fmt_state_reg;
        case (fmt_state_reg)
            F_IDLE:  if (start_accept) fmt_state_next = F_SIGN;
            F_SIGN:  if (can_push) fmt_state_next = F_DIGIT;
            F_DIGIT: if (can_push) fmt_state_next = (k_inc < n_digits) ? F_REQ : F_END;
            F_REQ:   fmt_state_next = F_WAIT;
            F_WAIT:  if (ac_answer) fmt_state_next = F_DIGIT;
            F_END:   if (can_push) fmt_state_next = F_DRAIN;
            F_DRAIN: if (drain_done) fmt_state_next = F_IDLE;
            default: fmt_state_next = F_IDLE;
        endcase
    end

    // Formatter outputs: symbol pushes, AC request and mode levels
    always_comb begin
        fifo_push      = 1'b0;
        push_data      = 5'b00000;
        order_io_to_ac = 1'b0;
        case (fmt_state_reg)
            F_SIGN: begin
                fifo_push = can_push;
                push_data = {4'b1111, sign_from_ac};
            end
            F_DIGIT: begin
                fifo_push = can_push;
                push_data = digit_sym;
            end
            F_END: begin
                fifo_push = can_push;
                push_data = END_CODE;
            end
            F_REQ:   order_io_to_ac = 1'b1;
            default: ;
        endcase
        output_active     = (fmt_state_reg != F_IDLE);
        shift_3_bit_to_ac = output_active && oct_reg;
        shift_4_bit_to_ac = output_active && dec_reg;
    end

    // Latched mode, digit counter and the end-of-word start pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            oct_reg         <= 1'b0;
            dec_reg         <= 1'b0;
            k_reg           <= '0;
            start_pulse_reg <= 1'b0;
        end else begin
            start_pulse_reg <= drain_done && !stop_after_output && !stop_output;
            if (start_accept) begin
                oct_reg <= oct_mode;
                dec_reg <= dec_mode;
                k_reg   <= '0;
            end else if (fmt_state_reg == F_DIGIT && can_push) begin
                k_reg <= k_inc;
            end
        end
    end

    // Device state register; an abort mid-handshake waits for ack to drop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dev_state_reg <= D_IDLE;
        end else if (stop_output) begin
            dev_state_reg <= (dev_state_reg != D_IDLE && output_ack_from_dev) ? D_FLUSH : D_IDLE;
        end else begin
            dev_state_reg <= dev_state_next;
        end
    end

    // Device next-state logic (4-phase handshake)
    always_comb begin
        dev_state_next = dev_state_reg;
        case (dev_state_reg)
            D_IDLE:  if (!fifo_empty) dev_state_next = D_RDY;
            D_RDY:   if (output_ack_from_dev) dev_state_next = D_ACK;
            D_ACK:   if (!output_ack_from_dev) dev_state_next = D_IDLE;
            D_FLUSH: if (!output_ack_from_dev) dev_state_next = D_IDLE;
            default: dev_state_next = D_IDLE;
        endcase
    end

    // Device outputs: rdy, head symbol, and pop on handshake completion
    always_comb begin
        output_rdy_to_dev  = (dev_state_reg == D_RDY);
        fifo_pop           = (dev_state_reg == D_ACK) && !output_ack_from_dev;
        output_data_to_dev = (dev_state_reg == D_RDY || dev_state_reg == D_ACK) ? fifo_head : 5'b00000;
    end

endmodule
